sys_bus_mx: RTL and testbench



---
 rtl/sys_bus_if.sv | 32 +++
 rtl/sys_bus_mx.sv | 201 ++++++++++++++++++++
 tb/tb_sys_bus_mx.sv | 237 +++++++++++++++++++++++
 3 files changed

// File: rtl/sys_bus_if.sv
// Bundled bus signals for sys_bus_mx: 'master' is the requesters' view, 'slave' is the fabric's view
// (the fabric is the slave of the masters and drives the peripheral side).
interface sys_bus_if #(
    parameter int NUM_MASTERS = 2,
    parameter int NUM_SLAVES  = 4,
    parameter int ADDR_W      = 32,
    parameter int DATA_W      = 32
);
    logic [NUM_MASTERS-1:0]        m_req;
    logic [NUM_MASTERS-1:0]        m_we;
    logic [NUM_MASTERS*ADDR_W-1:0] m_adr;
    logic [NUM_MASTERS*DATA_W-1:0] m_wdata;
    logic [NUM_MASTERS*DATA_W-1:0] m_rdata;
    logic [NUM_MASTERS-1:0]        m_ack;
    logic [NUM_MASTERS-1:0]        hold_flag;
    logic [NUM_SLAVES-1:0]         s_sel;
    logic [NUM_SLAVES-1:0]         s_we;
    logic [ADDR_W-1:0]             s_adr;
    logic [DATA_W-1:0]             s_wdata;
    logic [NUM_SLAVES*DATA_W-1:0]  s_rdata;
    logic                          bus_busy;

    modport master (
        output m_req, m_we, m_adr, m_wdata,
        input  m_rdata, m_ack, hold_flag
    );

    modport slave (
        input  m_req, m_we, m_adr, m_wdata, s_rdata,
        output m_rdata, m_ack, hold_flag, s_sel, s_we, s_adr, s_wdata, bus_busy
    );
endinterface

// File: rtl/sys_bus_mx.sv
// Multi-master / multi-slave system bus: arbitrate, decode, one ADDR cycle then one RESP (ack) cycle.
// Optional SYS_BUS_RR_EN selects round-robin arbitration; default is fixed priority (master 0 first).
//
// state | meaning
// IDLE  | no transfer in flight, waiting for any request
// ADDR  | granted master's address/data on the slave side, read data captured
// RESP  | ack + read data to granted master, re-arbitrate for back-to-back
module sys_bus_mx #(
    parameter int NUM_MASTERS = 2,
    parameter int NUM_SLAVES  = 4,
    parameter int ADDR_W      = 32,
    parameter int DATA_W      = 32,
    parameter int SEL_LSB     = 28,
    parameter int SEL_W       = 4
) (
    input logic     clk,
    input logic     rst,
    sys_bus_if.slave bus
);
    localparam int GW = (NUM_MASTERS > 1) ? $clog2(NUM_MASTERS) : 1;

    typedef enum logic [1:0] {IDLE, ADDR, RESP} state_t;

    state_t                  state_q, state_d;
    logic [GW-1:0]           grant_q, grant_d, arb_idx;
    logic                    arb_found;
    logic [NUM_MASTERS-1:0]  arb_req;
    logic [DATA_W-1:0]       rdata_q, rdata_d, cap_data;
    logic [ADDR_W-1:0]       adr_g;
    logic [DATA_W-1:0]       wdata_g;
    logic                    we_g;
    logic [SEL_W-1:0]        sel_idx;
    logic [NUM_SLAVES-1:0]   sel_hit;
    logic [NUM_MASTERS-1:0]  ack;
    logic [NUM_MASTERS*DATA_W-1:0] m_rdata_c;
    logic [NUM_SLAVES-1:0]   s_sel_c, s_we_c;
    logic [ADDR_W-1:0]       s_adr_c;
    logic [DATA_W-1:0]       s_wdata_c;
    logic                    busy_c;

    always_comb begin
        adr_g   = '0;
        wdata_g = '0;
        we_g    = 1'b0;
        for (int i = 0; i < NUM_MASTERS; i++) begin
            if (grant_q == GW'(i)) begin
                adr_g   = bus.m_adr[i*ADDR_W +: ADDR_W];
                wdata_g = bus.m_wdata[i*DATA_W +: DATA_W];
                we_g    = bus.m_we[i];
            end
        end
    end

    assign sel_idx = adr_g[SEL_LSB +: SEL_W];

    // Unmapped selects match no slave, so they read back zero and strobe nothing.
    always_comb begin
        sel_hit  = '0;
        cap_data = '0;
        for (int j = 0; j < NUM_SLAVES; j++) begin
            sel_hit[j] = (sel_idx == SEL_W'(j));
            if (sel_hit[j] && !we_g) begin
                cap_data = bus.s_rdata[j*DATA_W +: DATA_W];
            end
        end
    end

    // The master being acked is excluded so its still-held request is not served twice.
    always_comb begin
        arb_req = bus.m_req;
        if (state_q == RESP) begin
            for (int i = 0; i < NUM_MASTERS; i++) begin
                if (grant_q == GW'(i)) begin
                    arb_req[i] = 1'b0;
                end
            end
        end
    end

`ifdef SYS_BUS_RR_EN
    logic [GW-1:0] last_q, idx_hi, idx_lo;
    logic          found_hi, found_lo, grant_load;

    always_comb begin
        found_hi = 1'b0;
        found_lo = 1'b0;
        idx_hi   = '0;
        idx_lo   = '0;
        for (int i = NUM_MASTERS - 1; i >= 0; i--) begin
            if (arb_req[i]) begin
                if (GW'(i) > last_q) begin
                    found_hi = 1'b1;
                    idx_hi   = GW'(i);
                end else begin
                    found_lo = 1'b1;
                    idx_lo   = GW'(i);
                end
            end
        end
        arb_found = found_hi | found_lo;
        arb_idx   = found_hi ? idx_hi : idx_lo;
    end

    assign grant_load = arb_found && (state_q != ADDR);

    always_ff @(posedge clk) begin
        if (rst) begin
            last_q <= '0;
        end else if (grant_load) begin
            last_q <= arb_idx;
        end
    end
`else
    always_comb begin
        arb_found = 1'b0;
        arb_idx   = '0;
        for (int i = NUM_MASTERS - 1; i >= 0; i--) begin
            if (arb_req[i]) begin
                arb_found = 1'b1;
                arb_idx   = GW'(i);
            end
        end
    end
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            grant_q <= '0;
            rdata_q <= '0;
        end else begin
            state_q <= state_d;
            grant_q <= grant_d;
            rdata_q <= rdata_d;
        end
    end

    always_comb begin
        state_d = state_q;
        grant_d = grant_q;
        rdata_d = rdata_q;
        case (state_q)
            IDLE: begin
                if (arb_found) begin
                    grant_d = arb_idx;
                    state_d = ADDR;
                end
            end
            ADDR: begin
                rdata_d = cap_data;
                state_d = RESP;
            end
            RESP: begin
                if (arb_found) begin
                    grant_d = arb_idx;
                    state_d = ADDR;
                end else begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Outputs are forced quiet while rst is high so an aborted transfer never strobes.
    always_comb begin
        ack       = '0;
        m_rdata_c = '0;
        s_sel_c   = '0;
        s_we_c    = '0;
        s_adr_c   = '0;
        s_wdata_c = '0;
        busy_c    = 1'b0;
        if (!rst) begin
            busy_c = (state_q != IDLE);
            if (state_q == ADDR) begin
                s_sel_c   = sel_hit;
                s_we_c    = sel_hit & {NUM_SLAVES{we_g}};
                s_adr_c   = adr_g;
                s_wdata_c = wdata_g;
            end
            if (state_q == RESP) begin
                for (int i = 0; i < NUM_MASTERS; i++) begin
                    if (grant_q == GW'(i)) begin
                        ack[i]                         = 1'b1;
                        m_rdata_c[i*DATA_W +: DATA_W] = rdata_q;
                    end
                end
            end
        end
    end

    assign bus.m_ack     = ack;
    assign bus.m_rdata   = m_rdata_c;
    assign bus.hold_flag = bus.m_req & ~ack;
    assign bus.s_sel     = s_sel_c;
    assign bus.s_we      = s_we_c;
    assign bus.s_adr     = s_adr_c;
    assign bus.s_wdata   = s_wdata_c;
    assign bus.bus_busy  = busy_c;
endmodule

// File: tb/tb_sys_bus_mx.sv
// Scoreboard bench for sys_bus_mx: stimulus queues expected acks and address phases, monitor checks them.
module tb_sys_bus_mx;
    localparam int NM = 2;
    localparam int NS = 4;
    localparam int AW = 32;
    localparam int DW = 32;

    logic clk = 1'b0;
    logic rst;
    int   cyc = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    sys_bus_if #(.NUM_MASTERS(NM), .NUM_SLAVES(NS), .ADDR_W(AW), .DATA_W(DW)) bus ();

    sys_bus_mx #(
        .NUM_MASTERS(NM), .NUM_SLAVES(NS), .ADDR_W(AW), .DATA_W(DW), .SEL_LSB(28), .SEL_W(4)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    // Slave read data: slave j returns a fixed word.
    assign bus.s_rdata = {32'h4444_0003, 32'h0000_00A5, 32'h2222_0001, 32'h1111_0000};

    typedef struct {
        int          mst;
        logic [31:0] data;
        int          cyc;
    } ack_t;

    typedef struct {
        logic [3:0]  sel;
        logic [3:0]  we;
        logic [31:0] adr;
        logic [31:0] wdata;
    } aph_t;

    ack_t ack_q[$];
    aph_t aph_q[$];
    int   checks = 0;
    int   errors = 0;
    int   wr_count[NS];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Monitor: pops expectations whenever the DUT acks or presents an address phase.
    always @(negedge clk) begin
        ack_t e;
        aph_t a;
        for (int i = 0; i < NM; i++) begin
            if (bus.m_ack[i]) begin
                if (ack_q.size() == 0) begin
                    chk($sformatf("unexpected_ack_m%0d", i), 32'd1, 32'd0);
                end else begin
                    e = ack_q.pop_front();
                    chk("ack_master", i, e.mst);
                    chk("ack_rdata", bus.m_rdata[i*DW +: DW], e.data);
                    chk("ack_cycle", cyc, e.cyc);
                end
            end else if (bus.m_ack != '0) begin
                chk("non_acked_rdata_zero", bus.m_rdata[i*DW +: DW], 32'd0);
            end
        end
        if (!rst && (bus.s_sel != '0 || bus.s_we != '0)) begin
            for (int j = 0; j < NS; j++) begin
                if (bus.s_we[j]) wr_count[j]++;
            end
            if (aph_q.size() == 0) begin
                chk("unexpected_addr_phase", {28'd0, bus.s_sel}, 32'd0);
            end else begin
                a = aph_q.pop_front();
                chk("aph_sel", {28'd0, bus.s_sel}, {28'd0, a.sel});
                chk("aph_we", {28'd0, bus.s_we}, {28'd0, a.we});
                chk("aph_adr", bus.s_adr, a.adr);
                chk("aph_wdata", bus.s_wdata, a.wdata);
            end
        end
    end

    logic [NM-1:0]    acked, hold_s;
    logic [NS-1:0]    sel_s, we_s;
    logic             busy_s;
    logic [NM*DW-1:0] rd_s;

    // One cycle: sample at negedge, then behave like masters (drop m_req after ack).
    task automatic step();
        @(negedge clk);
        acked  = bus.m_ack;
        hold_s = bus.hold_flag;
        sel_s  = bus.s_sel;
        we_s   = bus.s_we;
        busy_s = bus.bus_busy;
        rd_s   = bus.m_rdata;
        @(posedge clk);
        #1;
        bus.m_req = bus.m_req & ~acked;
    endtask

    task automatic set_m(input int i, input logic we, input logic [31:0] adr, input logic [31:0] wd);
        bus.m_we[i]            = we;
        bus.m_adr[i*AW +: AW]  = adr;
        bus.m_wdata[i*DW +: DW] = wd;
    endtask

    task automatic exp_ack(input int m, input logic [31:0] d, input int c);
        ack_t e;
        e.mst = m; e.data = d; e.cyc = c;
        ack_q.push_back(e);
    endtask

    task automatic exp_aph(input logic [3:0] s, input logic [3:0] w, input logic [31:0] adr,
                           input logic [31:0] wd);
        aph_t a;
        a.sel = s; a.we = w; a.adr = adr; a.wdata = wd;
        aph_q.push_back(a);
    endtask

    int base, w0;
    logic exp_h;

    initial begin
        rst         = 1'b1;
        bus.m_req   = '0;
        bus.m_we    = '0;
        bus.m_adr   = '0;
        bus.m_wdata = '0;

        // Reset held with both masters requesting.
        set_m(0, 1'b0, 32'h0000_0010, 32'h0);
        set_m(1, 1'b0, 32'h3000_0000, 32'h0);
        bus.m_req = 2'b11;
        for (int k = 0; k < 3; k++) begin
            step();
            chk("rst_ack", {30'd0, acked}, 32'd0);
            chk("rst_sel", {28'd0, sel_s}, 32'd0);
            chk("rst_we", {28'd0, we_s}, 32'd0);
            chk("rst_busy", {31'd0, busy_s}, 32'd0);
            chk("rst_rdata", rd_s[DW-1:0] | rd_s[2*DW-1:DW], 32'd0);
        end
        rst  = 1'b0;
        base = cyc;
`ifdef SYS_BUS_RR_EN
        exp_aph(4'b1000, 4'b0000, 32'h3000_0000, 32'h0); exp_ack(1, 32'h4444_0003, base + 2);
        exp_aph(4'b0001, 4'b0000, 32'h0000_0010, 32'h0); exp_ack(0, 32'h1111_0000, base + 4);
`else
        exp_aph(4'b0001, 4'b0000, 32'h0000_0010, 32'h0); exp_ack(0, 32'h1111_0000, base + 2);
        exp_aph(4'b1000, 4'b0000, 32'h3000_0000, 32'h0); exp_ack(1, 32'h4444_0003, base + 4);
`endif
        repeat (6) step();
        chk("post_reset_idle", {31'd0, busy_s}, 32'd0);

        // Single write from master 0 to slave 1.
        base = cyc;
        w0   = wr_count[1];
        set_m(0, 1'b1, 32'h1000_0004, 32'hDEAD_BEEF);
        exp_aph(4'b0010, 4'b0010, 32'h1000_0004, 32'hDEAD_BEEF);
        exp_ack(0, 32'h0, base + 2);
        bus.m_req[0] = 1'b1;
        step(); chk("wr_c0_sel", {28'd0, sel_s}, 32'd0);
        step(); chk("wr_c1_sel", {28'd0, sel_s}, 32'h2); chk("wr_c1_we", {28'd0, we_s}, 32'h2);
        step(); chk("wr_c2_ack", {30'd0, acked}, 32'h1);
        repeat (3) step();
        chk("wr_slave1_once", wr_count[1] - w0, 32'd1);

        // Single read by master 1 from slave 2.
        base = cyc;
        set_m(1, 1'b0, 32'h2000_0000, 32'h0);
        exp_aph(4'b0100, 4'b0000, 32'h2000_0000, 32'h0);
        exp_ack(1, 32'h0000_00A5, base + 2);
        bus.m_req[1] = 1'b1;
        step(); chk("rd_hold_c0", {31'd0, hold_s[1]}, 32'd1);
        step(); chk("rd_hold_c1", {31'd0, hold_s[1]}, 32'd1);
        step(); chk("rd_hold_c2", {31'd0, hold_s[1]}, 32'd0); chk("rd_ack_c2", {30'd0, acked}, 32'h2);
        repeat (2) step();

        // Unmapped read from master 0.
        base = cyc;
        set_m(0, 1'b0, 32'hF000_0000, 32'h0);
        exp_ack(0, 32'h0, base + 2);
        bus.m_req[0] = 1'b1;
        step();
        step(); chk("unmap_sel", {28'd0, sel_s}, 32'd0); chk("unmap_we", {28'd0, we_s}, 32'd0);
        step(); chk("unmap_ack", {30'd0, acked}, 32'h1);
        repeat (2) step();

        // Abort: reset during the ADDR cycle of a write.
        set_m(0, 1'b1, 32'h1000_0008, 32'hCAFE_F00D);
        bus.m_req[0] = 1'b1;
        step();
        rst       = 1'b1;
        bus.m_req = '0;
        step();
        rst = 1'b0;
        step();
        chk("abort_ack", {30'd0, acked}, 32'd0);
        chk("abort_we", {28'd0, we_s}, 32'd0);
        chk("abort_busy", {31'd0, busy_s}, 32'd0);

        // Contention right after reset: both masters request together.
        base = cyc;
        set_m(0, 1'b1, 32'h3000_0008, 32'h1234_5678);
        set_m(1, 1'b0, 32'h0000_0000, 32'h0);
`ifdef SYS_BUS_RR_EN
        exp_aph(4'b0001, 4'b0000, 32'h0000_0000, 32'h0);         exp_ack(1, 32'h1111_0000, base + 2);
        exp_aph(4'b1000, 4'b1000, 32'h3000_0008, 32'h1234_5678); exp_ack(0, 32'h0, base + 4);
`else
        exp_aph(4'b1000, 4'b1000, 32'h3000_0008, 32'h1234_5678); exp_ack(0, 32'h0, base + 2);
        exp_aph(4'b0001, 4'b0000, 32'h0000_0000, 32'h0);         exp_ack(1, 32'h1111_0000, base + 4);
`endif
        bus.m_req = 2'b11;
        for (int k = 0; k < 5; k++) begin
            step();
`ifdef SYS_BUS_RR_EN
            exp_h = (k < 2);
`else
            exp_h = (k < 4);
`endif
            chk($sformatf("cont_hold1_c%0d", k), {31'd0, hold_s[1]}, {31'd0, exp_h});
        end
        repeat (2) step();

        for (int k = 0; k < 20 && (ack_q.size() + aph_q.size()) != 0; k++) step();
        chk("scoreboard_drained", ack_q.size() + aph_q.size(), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
